// File: rtl/shiftreg_pkg.sv
// Shared types and the reference step function for the universal shift register.
package shiftreg_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_SHL  = 3'd1,
    OP_SHR  = 3'd2,
    OP_ROL  = 3'd3,
    OP_ROR  = 3'd4,
    OP_ASR  = 3'd5
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Widest register the step functions can handle; callers zero-extend into this.
  localparam int STEP_MAX_W = 64;
  typedef logic [STEP_MAX_W-1:0] step_word_t;

  // Next register value for one step of width s on an n-bit register held
  // zero-extended in q. Unknown op codes hold.
  function automatic step_word_t shiftreg_step(input step_word_t q,
                                               input step_word_t din,
                                               input shift_op_e  op,
                                               input int         n,
                                               input int         s);
    step_word_t mask;
    step_word_t smask;
    step_word_t fill;
    step_word_t r;
    mask  = (n >= STEP_MAX_W) ? '1 : ((step_word_t'(1) << n) - step_word_t'(1));
    smask = (step_word_t'(1) << s) - step_word_t'(1);
    fill  = '0;
    case (op)
      OP_SHL:  r = ((q << s) | (din & smask)) & mask;
      OP_SHR:  r = (q >> s) | ((din & smask) << (n - s));
      OP_ROL:  r = ((q << s) | (q >> (n - s))) & mask;
      OP_ROR:  r = ((q >> s) | (q << (n - s))) & mask;
      OP_ASR: begin
        if (q[n-1]) fill = mask & ~(mask >> s);
        r = (q >> s) | fill;
      end
      default: r = q;
    endcase
    return r;
  endfunction

  // Bits leaving the register on one step (taken from the pre-step value).
  function automatic step_word_t shiftreg_sout(input step_word_t q,
                                               input shift_op_e  op,
                                               input int         n,
                                               input int         s);
    step_word_t smask;
    step_word_t r;
    smask = (step_word_t'(1) << s) - step_word_t'(1);
    case (op)
      OP_SHL, OP_ROL:         r = (q >> (n - s)) & smask;
      OP_SHR, OP_ROR, OP_ASR: r = q & smask;
      default:                r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shiftreg_step_comb.sv
// Combinational single-step datapath shared by the one-shot and multi-step paths.
module shiftreg_step_comb
  import shiftreg_pkg::*;
#(
  parameter int N = 8,
  parameter int S = 1
) (
  input  logic [N-1:0] q,
  input  logic [S-1:0] din,
  input  shift_op_e    op,
  output logic [N-1:0] q_nxt,
  output logic [S-1:0] sout_nxt,
  output logic         moves
);

  // Widen into the package word, apply the step, narrow back to register width.
  assign q_nxt    = N'(shiftreg_step(step_word_t'(q), step_word_t'(din), op, N, S));
  assign sout_nxt = S'(shiftreg_sout(step_word_t'(q), op, N, S));

  // HOLD and unassigned op codes leave sout alone.
  assign moves = op inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR};

endmodule

// File: rtl/shiftreg_univ.sv
// Universal shift register: parallel load, single-step shift, and a counted
// multi-step shifter with busy/done handshake.
//
//  state | meaning
//  IDLE  | waiting; load, start or shift_en accepted (that priority)
//  RUN   | one step per cycle with captured op, cnt counts down to 1
//  FIN   | one-cycle done pulse, then back to IDLE
module shiftreg_univ
  import shiftreg_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int S     = 1,
  localparam int AMT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [N-1:0]     pdata,
  input  logic [2:0]       op,
  input  logic             shift_en,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic [S-1:0]     din,
  output logic [N-1:0]     q,
  output logic [S-1:0]     sout,
  output logic             busy,
  output logic             done
);

  state_e           state, state_nxt;
  logic [AMT_W-1:0] cnt, cnt_nxt;
  shift_op_e        op_r, op_r_nxt;
  shift_op_e        op_in;
  shift_op_e        step_op;
  logic             load_q;
  logic             do_step;
  logic [N-1:0]     step_q;
  logic [S-1:0]     step_sout;
  logic             step_moves;

  assign op_in = shift_op_e'(op);

  shiftreg_step_comb #(.N(N), .S(S)) u_step (
    .q        (q),
    .din      (din),
    .op       (step_op),
    .q_nxt    (step_q),
    .sout_nxt (step_sout),
    .moves    (step_moves)
  );

  // Next-state, counter and datapath control decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_r_nxt  = op_r;
    load_q    = 1'b0;
    do_step   = 1'b0;
    step_op   = op_in;
    case (state)
      ST_IDLE: begin
        if (load) begin
          load_q = 1'b1;
        end else if (start) begin
          if (amount != '0) begin
            op_r_nxt  = op_in;
            cnt_nxt   = amount;
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_FIN;
          end
        end else if (shift_en) begin
          do_step = 1'b1;
        end
      end
      ST_RUN: begin
        step_op = op_r;
        if (load) begin
          load_q    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          do_step = 1'b1;
          cnt_nxt = cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
        if (load) load_q = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counter, captured op and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_r  <= OP_HOLD;
      q     <= '0;
      sout  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op_r  <= op_r_nxt;
      if (load_q) q <= pdata;
      else if (do_step) q <= step_q;
      if (do_step && step_moves) sout <= step_sout;
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_FIN);

  a_single_shl : assert property (@(posedge clk) disable iff (!rst_n)
    (state == ST_IDLE && !load && !start && shift_en && op_in == OP_SHL)
      |=> (q == $past({q[N-S-1:0], din})));

  a_single_shr : assert property (@(posedge clk) disable iff (!rst_n)
    (state == ST_IDLE && !load && !start && shift_en && op_in == OP_SHR)
      |=> (q == $past({din, q[N-1:S]})));

  a_done_pulse : assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);

  a_busy_done : assert property (@(posedge clk) disable iff (!rst_n)
    !(busy && done));

endmodule

// File: tb/tb_shiftreg_univ.sv
// Bench for shiftreg_univ: an S=1 and an S=2 instance share all controls and
// are checked each cycle against an arithmetic model, plus directed values.
module tb_shiftreg_univ;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [7:0] pdata = '0;
  logic [2:0] op = '0;
  logic       shift_en = 1'b0;
  logic       start = 1'b0;
  logic [3:0] amount = '0;
  logic       din1 = 1'b0;
  logic [1:0] din2 = '0;
  logic [7:0] q1, q2;
  logic       sout1;
  logic [1:0] sout2;
  logic       busy1, done1, busy2, done2;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  int m_q1, m_q2, m_so1, m_so2, m_rem, m_op;
  bit m_fin;

  always #5 clk = ~clk;

  shiftreg_univ #(.N(8), .S(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .load(load), .pdata(pdata), .op(op),
    .shift_en(shift_en), .start(start), .amount(amount), .din(din1),
    .q(q1), .sout(sout1), .busy(busy1), .done(done1)
  );

  shiftreg_univ #(.N(8), .S(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .load(load), .pdata(pdata), .op(op),
    .shift_en(shift_en), .start(start), .amount(amount), .din(din2),
    .q(q2), .sout(sout2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One step of s bits on an 8-bit value, as multiply/divide by 2^s.
  task automatic mstep(input int s, input int opc, input int d, inout int q, inout int so);
    int p, w, v, nq;
    p  = 1 << s;
    w  = 256 / p;
    nq = q;
    case (opc)
      1: begin so = q / w; nq = (q * p + d) % 256; end
      2: begin so = q % p; nq = q / p + d * w; end
      3: begin so = q / w; nq = (q * p + q / w) % 256; end
      4: begin so = q % p; nq = q / p + (q % p) * w; end
      5: begin
        so = q % p;
        v  = (q >= 128) ? q - 256 : q;
        nq = ((v - so) / p) & 255;
      end
      default: ;
    endcase
    q = nq;
  endtask

  task automatic model_reset();
    m_q1 = 0; m_q2 = 0; m_so1 = 0; m_so2 = 0;
    m_rem = 0; m_op = 0; m_fin = 0;
  endtask

  task automatic model_edge();
    if (m_rem > 0) begin
      if (load) begin
        m_q1 = pdata; m_q2 = pdata; m_rem = 0;
      end else begin
        mstep(1, m_op, din1, m_q1, m_so1);
        mstep(2, m_op, din2, m_q2, m_so2);
        m_rem--;
        if (m_rem == 0) m_fin = 1;
      end
    end else if (m_fin) begin
      m_fin = 0;
      if (load) begin m_q1 = pdata; m_q2 = pdata; end
    end else if (load) begin
      m_q1 = pdata; m_q2 = pdata;
    end else if (start) begin
      if (amount == 0) m_fin = 1;
      else begin m_rem = amount; m_op = op; end
    end else if (shift_en) begin
      mstep(1, op, din1, m_q1, m_so1);
      mstep(2, op, din2, m_q2, m_so2);
    end
  endtask

  task automatic check_all();
    chk("q_s1", q1, m_q1);
    chk("sout_s1", sout1, m_so1);
    chk("q_s2", q2, m_q2);
    chk("sout_s2", sout2, m_so2);
    chk("busy_s1", busy1, m_rem > 0);
    chk("done_s1", done1, m_fin);
    chk("busy_s2", busy2, m_rem > 0);
    chk("done_s2", done2, m_fin);
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_in();
    load = 0; start = 0; shift_en = 0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    chk("rst_q", q1, 8'h00);
    rst_n = 1'b1;

    // 1: single SHL step after load
    load = 1; pdata = 8'hA5; cyc();
    idle_in(); op = 3'd1; shift_en = 1; din1 = 1; din2 = 2'b01; cyc();
    chk("t1_q", q1, 8'h4B);
    chk("t1_sout", sout1, 1'b1);
    chk("t1_busy", busy1, 1'b0);

    // 2: ROR by 3 from 81
    idle_in(); load = 1; pdata = 8'h81; cyc();
    idle_in(); start = 1; op = 3'd4; amount = 4'd3; cyc();
    idle_in(); cyc(); chk("t2_q_c0", q1, 8'hC0);
    cyc(); chk("t2_q_60", q1, 8'h60);
    cyc(); chk("t2_q_30", q1, 8'h30);
    chk("t2_done", done1, 1'b1);
    chk("t2_sout", sout1, 1'b0);
    cyc(); chk("t2_done_end", done1, 1'b0);

    // 3: ASR by 2 steps from 90 (S=2 instance gives E4, F9)
    load = 1; pdata = 8'h90; cyc();
    idle_in(); start = 1; op = 3'd5; amount = 4'd2; cyc();
    idle_in(); cyc(); chk("t3_q_e4", q2, 8'hE4);
    cyc(); chk("t3_q_f9", q2, 8'hF9);
    chk("t3_sout", sout2, 2'b00);
    chk("t3_done", done2, 1'b1);
    cyc(); chk("t3_done_end", done2, 1'b0);

    // 4: zero amount goes straight to the done pulse
    start = 1; op = 3'd1; amount = 4'd0; cyc();
    idle_in();
    chk("t4_busy", busy1, 1'b0);
    chk("t4_done", done1, 1'b1);
    chk("t4_q", q1, 8'hE4);
    cyc(); chk("t4_done_end", done1, 1'b0);

    // 5: load aborts a running SHL; start/shift_en mid-run ignored
    load = 1; pdata = 8'h11; cyc();
    idle_in(); start = 1; op = 3'd1; amount = 4'd5; din1 = 1; din2 = 2'b11; cyc();
    op = 3'd4; amount = 4'd2; shift_en = 1; cyc();
    cyc();
    start = 0; shift_en = 0; load = 1; pdata = 8'h3C; cyc();
    chk("t5_q", q1, 8'h3C);
    chk("t5_busy", busy1, 1'b0);
    idle_in(); cyc(); chk("t5_no_done", done1, 1'b0);
    cyc();

    // 6: async reset in the middle of a run
    load = 1; pdata = 8'hF0; cyc();
    idle_in(); start = 1; op = 3'd3; amount = 4'd7; cyc();
    idle_in(); cyc();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_q", q1, 8'h00);
    chk("t6_sout", sout1, 1'b0);
    chk("t6_busy", busy1, 1'b0);
    chk("t6_done", done1, 1'b0);
    check_all();
    #2 rst_n = 1'b1;
    cyc();
    op = 3'd1; shift_en = 1; din1 = 1; din2 = 2'b10; cyc();
    chk("t6_idle_step", q1, 8'h01);
    idle_in();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      load     = ($urandom_range(0, 15) == 0);
      pdata    = 8'($urandom_range(0, 255));
      op       = 3'($urandom_range(0, 7));
      shift_en = 1'($urandom_range(0, 1));
      start    = ($urandom_range(0, 3) == 0);
      amount   = 4'($urandom_range(0, 15));
      din1     = 1'($urandom_range(0, 1));
      din2     = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
